bcd_to_bin: RTL
===============

# bcd_to_bin

Sequential BCD-to-binary converter: accepts a packed multi-digit BCD value and produces its unsigned binary equivalent using the reverse double-dabble algorithm (shift right, subtract 3 from any digit ≥ 8), one bit per clock. It is the inverse of the binary-to-BCD display path. It lets values entered or held as decimal digits (switch/keypad entry, stored display digits) feed the binary counters and comparators. It runs under a start/busy/done handshake and flags any non-decimal digit.

## Interface
- DIGITS, 4, number of BCD digits in bcd_in
- BIN_W, 14, width of bin_out; must satisfy 2^BIN_W > 10^DIGITS − 1 (default 14 bits covers 0..9999)
- clk  input  1  single clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a conversion; sampled only in IDLE
- bcd_in  input  4*DIGITS  packed BCD: digit 0 (ones) in [3:0], digit k in [4k+3:4k]; sampled only on an accepted start
- bin_out  output  BIN_W  binary result; registered, held until the next result
- busy  output  1  high while shifting
- done  output  1  one-cycle pulse when bin_out/err are updated
- err  output  1  set with done if any input digit was > 9; held with bin_out

## Operation
- Internal working register: {bcd_part[4*DIGITS-1:0], bin_part[BIN_W-1:0]}, plus a bit counter of width ceil(log2(BIN_W+1)).
- States: IDLE, SHIFT, DONE.
- IDLE with start=1: capture bcd_in.
  - Any digit > 9: go to DONE with the error flag staged.
  - Otherwise: load bcd_part=bcd_in, bin_part=0, counter=BIN_W, and go to SHIFT.
- IDLE with start=0: remain in IDLE; all outputs hold.
- SHIFT, each cycle:
  - Shift the whole register right by 1, with 0 entering the bcd_part MSB.
  - Then, for every digit of the shifted bcd_part, subtract 3 if the digit is ≥ 8. All digits are corrected in parallel in the same cycle.
  - Decrement counter. When counter is 1 before decrementing, the next state is DONE.
- DONE (exactly one cycle):
  - done=1.
  - Valid conversion: bin_out=bin_part and err=0.
  - Invalid conversion: bin_out=0 and err=1.
  - Next state is IDLE.
- After BIN_W shifts, bcd_part is zero for every valid input. This is a verification invariant, not a checked output.
- start is ignored in SHIFT and DONE; there is no queuing. A start held high is accepted again on the first IDLE cycle.
- bcd_in may change freely while busy; it has no effect.

## Timing
- Reset values: state=IDLE, bin_out=0, busy=0, done=0, err=0, counter=0, working register=0.
- Reset asserted in any state, including mid-SHIFT: everything returns to reset values on that edge. The partial result is discarded and no done pulse occurs.
- Valid conversion, with start accepted at the edge ending cycle 0:
  - busy=1 in cycles 1..BIN_W.
  - done=1 and busy=0 in cycle BIN_W+1, with bin_out/err valid in that same cycle.
  - Earliest next accept is the edge ending cycle BIN_W+2.
  - Default latency: done in cycle 15; throughput is one conversion per 16 cycles.
- Invalid digit:
  - done=1 and err=1 in cycle 1; busy never asserts.
  - Earliest next accept is at the end of cycle 2.
- done is a single-cycle pulse.
- bin_out and err change only in the DONE cycle and are stable otherwise.
- busy and done are never high simultaneously.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then bcd_in=16'h0000 with start -> busy cycles 1..14, done in cycle 15, bin_out=0, err=0.
- bcd_in=16'h9999 -> done in cycle 15, bin_out=14'd9999 (0x270F), err=0. Also check bcd_in=16'h1234 -> bin_out=1234 (0x4D2).
- bcd_in=16'h12A4 (digit 1 = 0xA) -> done in cycle 1, err=1, bin_out=0, busy never high. A following valid start with 16'h0007 -> bin_out=7, err=0.
- Start with 16'h0500. Pulse start again with 16'h0001 in cycle 5 and change bcd_in during busy -> second start ignored, result 500, exactly one done pulse.
- Start with 16'h0777 and assert reset in cycle 6 -> all outputs 0 on the next edge, no done. Then start with 16'h0042 -> done 15 cycles later, bin_out=42.
- Hold start high continuously with 16'h0100 -> done in cycles 15, 31, 47 (one accept per 16 cycles), bin_out=100 each time. Random sweep of all valid 0..9999 values against a reference model.

Source files
------------

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one result bit per clock.
// Start/busy/done handshake; any non-decimal input digit is reported through err.
module bcd_to_bin #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned CntW = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e              state_q;
    logic [BcdW-1:0]     bcd_q;
    logic [BIN_W-1:0]    bin_q;
    logic [CntW-1:0]     cnt_q;
    logic [BIN_W-1:0]    bin_out_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    logic [BcdW+BIN_W-1:0] shifted;
    logic [BcdW-1:0]       corr_bcd;
    logic [BIN_W-1:0]      shift_bin;
    logic                  in_err;

    // Shift the whole working register right, then pull every digit >= 8 back by 3 in parallel.
    always_comb begin
        shifted   = {bcd_q, bin_q} >> 1;
        corr_bcd  = shifted[BIN_W +: BcdW];
        shift_bin = shifted[BIN_W-1:0];
        for (int k = 0; k < DIGITS; k++) begin
            if (corr_bcd[4*k +: 4] >= 4'd8) begin
                corr_bcd[4*k +: 4] = corr_bcd[4*k +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        in_err = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_in[4*k +: 4] > 4'd9) begin
                in_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            bcd_q     <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            bin_out_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (in_err) begin
                            state_q   <= StDone;
                            done_q    <= 1'b1;
                            err_q     <= 1'b1;
                            bin_out_q <= '0;
                        end else begin
                            state_q <= StShift;
                            bcd_q   <= bcd_in;
                            bin_q   <= '0;
                            cnt_q   <= CntW'(BIN_W);
                            busy_q  <= 1'b1;
                        end
                    end
                end
                StShift: begin
                    bcd_q <= corr_bcd;
                    bin_q <= shift_bin;
                    cnt_q <= cnt_q - 1'b1;
                    // Outputs are registered, so the result is published on the last shift edge.
                    if (cnt_q == CntW'(1)) begin
                        state_q   <= StDone;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        err_q     <= 1'b0;
                        bin_out_q <= shift_bin;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bin_out = bin_out_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule
